spectrum_peak_scan_ctrl: RTL
============================

Name: spectrum_peak_scan_ctrl

Overview:
- Sequences one peak search over a bin range of the FFT output RAM.
- Issues RAM reads and forms the saturated power |X|^2 = re^2 + im^2 per bin.
- Streams the powers into the serial peak-finder datapath (start/data_in/index interface), then captures the finder's result.
- Sits between the FFT output buffer and the pitch-estimation logic; reports the absolute peak bin with a done pulse.

Parameters:
- MEM_LATENCY, 2, RAM read latency in cycles, from mem_addr to mem_re/mem_im valid (1..4).
- BIN_W, 9, bin/address width; the range is 0..2^BIN_W-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  one-cycle request to start a scan; sampled only in IDLE.
- lo_bin  input  BIN_W  first bin to scan; sampled with trigger.
- hi_bin  input  BIN_W  last bin to scan, inclusive; sampled with trigger.
- mem_addr  output  BIN_W  FFT RAM read address.
- mem_re  input  16  signed real part, valid MEM_LATENCY cycles after the address.
- mem_im  input  16  signed imaginary part, same timing as mem_re.
- pf_start  output  1  drives peak-finder start; high only with the first datum.
- pf_data  output  32  signed power to the peak finder.
- pf_index  output  BIN_W  index to the peak finder (position-1 convention, below).
- pf_peak_index  input  BIN_W  peak finder result: position relative to the first datum.
- busy  output  1  high from the cycle after an accepted trigger until done.
- done  output  1  one-cycle pulse when the result is valid.
- peak_bin  output  BIN_W  absolute peak bin; held until the next done.
- range_err  output  1  set with done when hi_bin < lo_bin; cleared on the next accepted trigger.

Behaviour:
- Reset: state IDLE.
  - mem_addr=0, pf_start=0, pf_data=0, pf_index=0.
  - busy=0, done=0, peak_bin=0, range_err=0.
  - MEM_LATENCY valid pipe cleared.
- Reset mid-scan aborts the scan. No done is produced and all outputs take their reset values.
- States:
  - IDLE: waiting for trigger.
  - ISSUE: one read address per cycle.
  - DRAIN: waiting for the pipeline to empty.
  - CAPTURE: wait one cycle for the finder output.
  - DONE: pulse done.
- Transitions:
  - IDLE->ISSUE on trigger with hi_bin>=lo_bin. lo_bin is latched and N = hi_bin-lo_bin+1 (1..512; counter is BIN_W+1 bits).
  - IDLE->DONE on trigger with hi_bin<lo_bin. Sets range_err=1, peak_bin=lo_bin; done is asserted in cycle T+1.
  - ISSUE->DRAIN after N addresses lo_bin..hi_bin in consecutive cycles.
  - DRAIN->CAPTURE when the last datum is on pf_data.
  - CAPTURE->DONE.
  - DONE->IDLE.
- Trigger timing and re-trigger:
  - trigger in cycle T: mem_addr=lo_bin in cycle T+1.
  - trigger while busy is ignored.
  - trigger in the DONE cycle is ignored. A trigger is accepted in the cycle after done.
- Power stage: RAM data is registered one stage after arrival.
  - pf_data = re*re + im*im, signed 16x16 products summed in 33 bits.
  - The result saturates to 32'h7FFFFFFF when it exceeds 2^31-1. The only such case is re=im=-32768.
  - pf_data is always >= 0.
- Stream timing:
  - The datum for scan position p (0..N-1) is on pf_data in cycle T+2+MEM_LATENCY+p.
  - pf_start=1 only for p=0; pf_index = p-1 mod 2^BIN_W.
  - This lets the finder's index+1 convention yield pf_peak_index = p of the strict maximum.
  - Ties resolve to the lowest p, since the finder updates only on strictly greater data.
- Outside the stream: pf_start=0 and pf_data=0; the finder's contents are don't-care.
- Capture:
  - pf_peak_index is valid in cycle T+2+MEM_LATENCY+N and is sampled in CAPTURE.
  - peak_bin = lo_bin + pf_peak_index (mod 2^BIN_W).
  - done=1 and busy=0 in cycle T+3+MEM_LATENCY+N.
- mem_addr holds its last value outside ISSUE.

Test Plan:
- Normal scan: MEM_LATENCY=2, lo=10, hi=13, (re,im) = (1,0),(3,4),(10,0),(2,2); trigger at T -> pf_data 1,25,100,8 in cycles T+4..T+7; done at T+9; peak_bin=12; range_err=0.
- Tie and single bin: lo=5, hi=7, powers 9,4,9 -> peak_bin=5. Then lo=hi=20 -> peak_bin=20 with done at T+6.
- Saturation: lo=0, hi=3, bin 2 = (-32768,-32768), others (100,100) -> pf_data for bin 2 = 0x7FFFFFFF; peak_bin=2.
- Full range: lo=0, hi=511, single maximum at bin 511 -> 512 consecutive addresses; done at T+517; peak_bin=511.
- Range error: lo=30, hi=29 -> no mem_addr activity; done at T+1; range_err=1; peak_bin=30.
- Control: trigger pulsed mid-scan -> ignored, one done only. reset at T+5 of a scan -> busy=0 next cycle, no done, all outputs at reset values. A following trigger scans normally.

Source files
------------

// File: rtl/spectrum_peak_scan_ctrl.sv
// rtl/spectrum_peak_scan_ctrl.sv - sequences one FFT-bin peak search through the serial peak finder
// Reads bins lo..hi, forms saturated |X|^2, streams it to the finder and reports the absolute peak bin.
module spectrum_peak_scan_ctrl #(
   parameter int MEM_LATENCY = 2,
   parameter int BIN_W       = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    trigger,
   input  logic [BIN_W-1:0]        lo_bin,
   input  logic [BIN_W-1:0]        hi_bin,
   output logic [BIN_W-1:0]        mem_addr,
   input  logic signed [15:0]      mem_re,
   input  logic signed [15:0]      mem_im,
   output logic                    pf_start,
   output logic signed [31:0]      pf_data,
   output logic [BIN_W-1:0]        pf_index,
   input  logic [BIN_W-1:0]        pf_peak_index,
   output logic                    busy,
   output logic                    done,
   output logic [BIN_W-1:0]        peak_bin,
   output logic                    range_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_DRAIN, S_CAPTURE, S_DONE
   } state_t;

   state_t state, state_nx;

   logic [BIN_W:0]          n_len;
   logic [BIN_W:0]          cnt;
   logic [BIN_W-1:0]        lo_q;
   logic [MEM_LATENCY-1:0]  v_pipe;
   logic [MEM_LATENCY-1:0]  f_pipe;
   logic [MEM_LATENCY-1:0]  l_pipe;
   logic                    out_last;
   logic                    accept;
   logic                    range_bad;
   logic                    issue_v;
   logic                    issue_first;
   logic                    issue_last;
   logic signed [31:0]      re_sq;
   logic signed [31:0]      im_sq;
   logic [32:0]             pwr_sum;
   logic [31:0]             pwr_sat;

   assign range_bad   = (hi_bin < lo_bin);
   // cnt holds the number of addresses issued including the current one
   assign issue_first = issue_v && (cnt == (BIN_W+1)'(1));
   assign issue_last  = issue_v && (cnt == n_len);

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      issue_v  = 1'b0;
      case (state)
         S_IDLE: begin
            if (trigger) begin
               accept   = 1'b1;
               state_nx = range_bad ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            busy    = 1'b1;
            issue_v = 1'b1;
            if (cnt == n_len) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (out_last) state_nx = S_CAPTURE;
         end
         S_CAPTURE: begin
            busy     = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         mem_addr  <= '0;
         cnt       <= '0;
         n_len     <= '0;
         lo_q      <= '0;
         peak_bin  <= '0;
         range_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            lo_q      <= lo_bin;
            range_err <= range_bad;
            if (range_bad) begin
               peak_bin <= lo_bin;
            end else begin
               mem_addr <= lo_bin;
               cnt      <= (BIN_W+1)'(1);
               n_len    <= {1'b0, hi_bin} - {1'b0, lo_bin} + (BIN_W+1)'(1);
            end
         end else if (issue_v && (cnt != n_len)) begin
            mem_addr <= mem_addr + 1'b1;
            cnt      <= cnt + 1'b1;
         end
         if (state == S_CAPTURE) peak_bin <= lo_q + pf_peak_index;
      end
   end

   // Squares are non-negative, so the 33-bit sum only overflows 2^31-1 for re=im=-32768
   assign re_sq   = 32'(mem_re) * 32'(mem_re);
   assign im_sq   = 32'(mem_im) * 32'(mem_im);
   assign pwr_sum = {1'b0, re_sq} + {1'b0, im_sq};
   assign pwr_sat = (pwr_sum[32:31] != 2'b00) ? 32'h7FFF_FFFF : pwr_sum[31:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         v_pipe   <= '0;
         f_pipe   <= '0;
         l_pipe   <= '0;
         pf_start <= 1'b0;
         pf_data  <= '0;
         pf_index <= '0;
         out_last <= 1'b0;
      end else begin
         v_pipe[0] <= issue_v;
         f_pipe[0] <= issue_first;
         l_pipe[0] <= issue_last;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            f_pipe[i] <= f_pipe[i-1];
            l_pipe[i] <= l_pipe[i-1];
         end
         pf_start <= f_pipe[MEM_LATENCY-1];
         out_last <= l_pipe[MEM_LATENCY-1];
         // Index runs one behind position so the finder's index+1 lands on the position
         if (v_pipe[MEM_LATENCY-1]) begin
            pf_data  <= pwr_sat;
            pf_index <= f_pipe[MEM_LATENCY-1] ? '1 : pf_index + 1'b1;
         end else begin
            pf_data  <= '0;
         end
      end
   end

endmodule
